vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of the 640x480 sync block. It divides the board clock down to a pixel tick and runs horizontal and vertical counters from fully parametrised porch, sync and active widths. It produces registered, glitch-free sync and blanking signals with selectable polarity, plus tick, line-start and frame-start strobes for downstream pixel generators and frame-buffer readers. It sits between the board clock and the pixel/colour pipeline.

## Interface
- CLK_DIV, 4, clk cycles per pixel (≥1); 100 MHz/4 = 25 MHz pixel rate
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)
- CW, 11, pixel_x/pixel_y width; must hold H_TOTAL-1 and V_TOTAL-1
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; low freezes the divider, counters and all outputs
- pixel_x  out  CW  current horizontal position, 0..H_TOTAL-1
- pixel_y  out  CW  current vertical position, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- video_on  out  1  high while (pixel_x, pixel_y) is in the active area
- pix_tick  out  1  one-clk pulse in the cycle the counters take new values
- line_start  out  1  pulses with pix_tick when pixel_x becomes 0
- frame_start  out  1  pulses with pix_tick when (pixel_x, pixel_y) becomes (0, 0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. The defaults give 800 and 525.
- Divider `div` counts 0..CLK_DIV-1 while en=1. The internal advance condition is en && div==CLK_DIV-1. With CLK_DIV=1, the block advances on every enabled cycle.
- On advance, pixel_x increments and wraps from H_TOTAL-1 to 0.
- On an x-wrap, pixel_y increments and wraps from V_TOTAL-1 to 0. pixel_y changes only on an x-wrap.
- hsync is active iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
- vsync is active iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
- video_on = x < H_ACTIVE && y < V_ACTIVE.
- All outputs are flops. Sync, video_on and the strobes are decoded from the next-state counts, so they align with pixel_x/pixel_y in the same cycle.
- Reset state is the last pixel of the frame:
  - pixel_x = H_TOTAL-1 and pixel_y = V_TOTAL-1; div = 0.
  - hsync = ~HS_POL and vsync = ~VS_POL (inactive); video_on = 0.
  - pix_tick = line_start = frame_start = 0.
- en=0 mid-line holds every output; strobes drop to 0. en=1 resumes from the held div value with no lost or duplicated pixel.
- Reset asserted mid-frame returns to the reset state asynchronously. The first advance after release enters (0, 0) and pulses frame_start.

## Timing
- Advance-to-output latency is 0: new pixel_x/pixel_y and decoded outputs appear together, one clk edge after the advance condition.
- Pixel period is CLK_DIV clk cycles. Line period is H_TOTAL·CLK_DIV clk cycles. Frame period is H_TOTAL·V_TOTAL·CLK_DIV clk cycles (1,680,000 with defaults).
- First advance after rst release occurs on the CLK_DIV-th enabled clk edge.
- frame_start implies line_start, and line_start implies pix_tick.
- Strobes are exactly 1 clk wide, including when CLK_DIV=1. With CLK_DIV=1 and en held high, pix_tick is continuously high.

## Structure
- Shared package `vga_timing_pkg` holds:
  - Mode constants for 640x480@60: 640/16/96/48, 480/10/2/33, CLK_DIV 4.
  - Mode constants for 800x600@60: 800/40/128/88, 600/1/4/23, 40 MHz pixel.
  - Total-count helper functions.
- Sub-module `vga_axis_counter` (parameters ACTIVE, FP, SYNC, BP, POL, CW):
  - Inputs: step.
  - Outputs: count, wrap, sync, active.
  - Instantiated twice. The horizontal instance steps on advance; the vertical instance steps on advance && h-wrap.

## Test plan
- Reset, defaults: during rst, pixel_x=799, pixel_y=524, hsync=vsync=1, video_on=0. Release → on the 4th clk edge, pixel_x=pixel_y=0, frame_start=line_start=pix_tick=1 for one clk, video_on=1.
- Line timing: hsync is low for exactly 96 consecutive pixels, x=656..751 (384 clk). video_on falls at x=640. line_start repeats every 3200 clk.
- Frame timing: vsync is low only on y=490..491 (1600 pixel ticks). frame_start repeats every 1,680,000 clk.
- en gating: drop en for 7 clk at x=100 → pixel_x stays 100 and no strobes fire; after re-enable, x=101 occurs exactly (CLK_DIV-div_held) enabled clks later.
- Mid-frame reset: rst pulse at (x=300, y=200) → immediate reset state; next frame_start occurs 4 clk after release.
- Alternate params: CLK_DIV=1, HS_POL=VS_POL=1, H=8/2/3/2, V=4/1/2/1.
  - pix_tick is high every cycle; hsync is high for x=10..12.
  - vsync is high for y=5..6.
  - frame_start fires every 15·8=120 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and total-count helpers for the raster timing generator.
// Both supported modes are described per axis as active/front-porch/sync/back-porch widths.
package vga_timing_pkg;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } axis_timing_t;

  localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam int unsigned  VGA640_CLK_DIV = 4;

  localparam axis_timing_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88};
  localparam axis_timing_t SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23};
  localparam int unsigned  SVGA800_PIXEL_HZ = 40_000_000;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned axis_total_of(input axis_timing_t t);
    return axis_total(t.active, t.fp, t.sync, t.bp);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync/active decode of the next count,
// so the parent can register those decodes in step with the count itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_o,
  output logic          sync_o,
  output logic          active_o
);

  localparam int unsigned   TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (step_i) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap_o  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Resets to the last position so the first step lands exactly on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= LAST;
    else     count_q <= count_d;
  end

  assign count_o  = count_q;
  assign sync_o   = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? POL : ~POL;
  assign active_o = (count_d < ACT_END);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: clock divider, x/y axis counters and
// registered sync, blanking and strobe outputs aligned with the pixel position.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA640_CLK_DIV,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  output logic [CW-1:0] pixel_x_o,
  output logic [CW-1:0] pixel_y_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          video_on_o,
  output logic          pix_tick_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          advance;
  logic          h_wrap, v_wrap;
  logic          hsync_d, vsync_d, h_active_d, v_active_d;

  assign advance = en_i && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en_i) div_d = advance ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
  ) u_h (
    .clk(clk), .rst(rst), .step_i(advance),
    .count_o(pixel_x_o), .wrap_o(h_wrap), .sync_o(hsync_d), .active_o(h_active_d)
  );

  // h_wrap already implies advance, so the vertical axis steps once per line.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
  ) u_v (
    .clk(clk), .rst(rst), .step_i(h_wrap),
    .count_o(pixel_y_o), .wrap_o(v_wrap), .sync_o(vsync_d), .active_o(v_active_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      video_on_o    <= 1'b0;
      pix_tick_o    <= 1'b0;
      line_start_o  <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      hsync_o       <= hsync_d;
      vsync_o       <= vsync_d;
      video_on_o    <= h_active_d && v_active_d;
      pix_tick_o    <= advance;
      line_start_o  <= h_wrap;
      frame_start_o <= h_wrap && v_wrap;
    end
  end

endmodule
